// File: rtl/screen_pkg.sv
// Shared types and constants for the game screen sequencer: state encoding,
// layer bit positions in the objects-mux enable vector, and background selects.
package screen_pkg;

    typedef enum logic [2:0] {
        ST_SPLASH    = 3'd0,
        ST_PLAY      = 3'd1,
        ST_DYING     = 3'd2,
        ST_WIN       = 3'd3,
        ST_GAME_OVER = 3'd4
    } screen_state_t;

    localparam int LYR_MONKEY     = 6;
    localparam int LYR_SCOREBOARD = 5;
    localparam int LYR_NUMBERS    = 4;
    localparam int LYR_OPERAND    = 3;
    localparam int LYR_ROPES      = 2;
    localparam int LYR_BLOCKS     = 1;
    localparam int LYR_WATER      = 0;

    localparam logic [1:0] BG_SPLASH    = 2'd0;
    localparam logic [1:0] BG_LEVEL     = 2'd1;
    localparam logic [1:0] BG_GAME_OVER = 2'd2;
    localparam logic [1:0] BG_WIN       = 2'd3;

    localparam logic [6:0] LAYERS_SPLASH = 7'(1 << LYR_SCOREBOARD);
    localparam logic [6:0] LAYERS_SCORE  = 7'((1 << LYR_SCOREBOARD) | (1 << LYR_NUMBERS));
    localparam logic [6:0] LAYERS_LEVEL  = 7'((1 << LYR_SCOREBOARD) | (1 << LYR_NUMBERS)
                                             | (1 << LYR_OPERAND) | (1 << LYR_ROPES)
                                             | (1 << LYR_BLOCKS) | (1 << LYR_WATER));

    // Overrides the monkey bit of a layer set; used for the blinking screens.
    function automatic logic [6:0] with_monkey(input logic [6:0] base, input logic on);
        logic [6:0] result;
        result             = base;
        result[LYR_MONKEY] = on;
        return result;
    endfunction

endpackage

// File: rtl/screen_sequencer_if.sv
// Frame/event inputs and mux-configuration outputs of the screen sequencer.
interface screen_sequencer_if;
    logic       startOfFrame;
    logic       startKey;
    logic       deathEvent;
    logic       goalEvent;
    logic [6:0] layerEnable;
    logic [1:0] backgroundSel;
    logic [1:0] livesLeft;
    logic       respawnPulse;
    logic [2:0] gameState;

    modport slave (
        input  startOfFrame, startKey, deathEvent, goalEvent,
        output layerEnable, backgroundSel, livesLeft, respawnPulse, gameState
    );

    modport master (
        output startOfFrame, startKey, deathEvent, goalEvent,
        input  layerEnable, backgroundSel, livesLeft, respawnPulse, gameState
    );
endinterface

// File: rtl/screen_sequencer_frame_counter.sv
// Saturating 8-bit frame counter: counts tick pulses, cleared on request.
module frame_counter (
    input  logic       clk,
    input  logic       resetN,
    input  logic       clear,
    input  logic       tick,
    output logic [7:0] count
);

    logic [7:0] count_reg;

    // Clear has priority so a tick on a state-change edge is dropped.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (tick && (count_reg != 8'hFF)) begin
            count_reg <= count_reg + 8'd1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/screen_sequencer.sv
// Game-level screen FSM: sequences splash/play/dying/win/game-over in frame
// units and drives the objects-mux layer enables, background and lives.
module screen_sequencer
    import screen_pkg::*;
#(
    parameter int SPLASH_MIN_FRAMES = 60,
    parameter int DYING_FRAMES      = 120,
    parameter int BLINK_FRAMES      = 8,
    parameter int LIVES             = 3
) (
    input  logic              clk,
    input  logic              resetN,
    screen_sequencer_if.slave bus
);

    localparam logic [7:0] SPLASH_MIN = 8'(SPLASH_MIN_FRAMES);
    localparam logic [7:0] DYING_LEN  = 8'(DYING_FRAMES);
    localparam logic [1:0] LIVES_INIT = 2'(LIVES);
    localparam int         BLINK_BIT  = $clog2(BLINK_FRAMES);

    screen_state_t state_reg, state_next;
    logic [1:0]    lives_reg, lives_next;
    logic          respawn_reg, respawn_next;
    logic [7:0]    frame_cnt;
    logic          state_change;

    logic [6:0]    layer_enable_reg;
    logic [1:0]    background_sel_reg;
    logic [1:0]    lives_left_reg;
    logic          respawn_pulse_reg;
    screen_state_t game_state_reg;

    frame_counter u_frame_counter (
        .clk    (clk),
        .resetN (resetN),
        .clear  (state_change),
        .tick   (bus.startOfFrame),
        .count  (frame_cnt)
    );

    always_comb begin
        state_next   = state_reg;
        lives_next   = lives_reg;
        respawn_next = 1'b0;
        case (state_reg)
            ST_SPLASH: begin
                if (bus.startKey && (frame_cnt >= SPLASH_MIN)) begin
                    state_next   = ST_PLAY;
                    lives_next   = LIVES_INIT;
                    respawn_next = 1'b1;
                end
            end
            ST_PLAY: begin
                if (bus.deathEvent) begin
                    state_next = ST_DYING;
                end else if (bus.goalEvent) begin
                    state_next = ST_WIN;
                end
            end
            ST_DYING: begin
                if (frame_cnt == DYING_LEN) begin
                    lives_next = (lives_reg == 2'd0) ? 2'd0 : lives_reg - 2'd1;
                    if (lives_reg <= 2'd1) begin
                        state_next = ST_GAME_OVER;
                    end else begin
                        state_next   = ST_PLAY;
                        respawn_next = 1'b1;
                    end
                end
            end
            ST_WIN: begin
                if (frame_cnt == DYING_LEN) begin
                    state_next = ST_SPLASH;
                end
            end
            ST_GAME_OVER: begin
                if (bus.startKey && (frame_cnt >= SPLASH_MIN)) begin
                    state_next = ST_SPLASH;
                end
            end
            default: state_next = ST_SPLASH;
        endcase
    end

    assign state_change = (state_next != state_reg);

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_reg   <= ST_SPLASH;
            lives_reg   <= 2'd0;
            respawn_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            lives_reg   <= lives_next;
            respawn_reg <= respawn_next;
        end
    end

    // Outputs trail the state register by one clk; blink is on for the first BLINK_FRAMES.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            layer_enable_reg   <= LAYERS_SPLASH;
            background_sel_reg <= BG_SPLASH;
            lives_left_reg     <= 2'd0;
            respawn_pulse_reg  <= 1'b0;
            game_state_reg     <= ST_SPLASH;
        end else begin
            lives_left_reg    <= lives_reg;
            respawn_pulse_reg <= respawn_reg;
            game_state_reg    <= state_reg;
            case (state_reg)
                ST_SPLASH: begin
                    layer_enable_reg   <= LAYERS_SPLASH;
                    background_sel_reg <= BG_SPLASH;
                end
                ST_PLAY: begin
                    layer_enable_reg   <= with_monkey(LAYERS_LEVEL, 1'b1);
                    background_sel_reg <= BG_LEVEL;
                end
                ST_DYING: begin
                    layer_enable_reg   <= with_monkey(LAYERS_LEVEL, ~frame_cnt[BLINK_BIT]);
                    background_sel_reg <= BG_LEVEL;
                end
                ST_WIN: begin
                    layer_enable_reg   <= with_monkey(LAYERS_SCORE, ~frame_cnt[BLINK_BIT]);
                    background_sel_reg <= BG_WIN;
                end
                ST_GAME_OVER: begin
                    layer_enable_reg   <= LAYERS_SCORE;
                    background_sel_reg <= BG_GAME_OVER;
                end
                default: begin
                    layer_enable_reg   <= LAYERS_SPLASH;
                    background_sel_reg <= BG_SPLASH;
                    game_state_reg     <= ST_SPLASH;
                end
            endcase
        end
    end

    assign bus.layerEnable   = layer_enable_reg;
    assign bus.backgroundSel = background_sel_reg;
    assign bus.livesLeft     = lives_left_reg;
    assign bus.respawnPulse  = respawn_pulse_reg;
    assign bus.gameState     = game_state_reg;

endmodule
